// File: rtl/spi_regfile_pkg.sv
// Shared constants and state encoding for the SPI register-file transaction stage.
package spi_regfile_pkg;

   localparam int          CMD_RD_BIT = 7;
   localparam int          ADDR_W     = 7;
   localparam logic [7:0]  TX_RST     = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WRITE = 2'd2,
      READ  = 2'd3
   } state_t;

endpackage

// File: rtl/spi_regbank.sv
// Register bank: reg 0 is a fixed ID (not stored), regs 1..NREGS-1 are R/W storage.
module spi_regbank
   import spi_regfile_pkg::*;
#(
   parameter int          NREGS   = 16,
   parameter logic [7:0]  ID_VAL  = 8'h5A,
   parameter logic [7:0]  OOR_VAL = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_we,
   input  logic [ADDR_W-1:0]    i_waddr,
   input  logic [7:0]           i_wdata,
   input  logic [ADDR_W-1:0]    i_raddr,
   output logic [7:0]           o_rdata,
   output logic [NREGS*8-1:0]   o_regs_q
);

   logic [7:0] r_mem [1:NREGS-1];

   // Address 0 and addresses >= NREGS match no entry, so such writes are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) r_mem[i] <= 8'h00;
      end else if (i_we) begin
         for (int i = 1; i < NREGS; i++) begin
            if (i_waddr == ADDR_W'(i)) r_mem[i] <= i_wdata;
         end
      end
   end

   always_comb begin
      o_rdata = OOR_VAL;
      for (int i = 1; i < NREGS; i++) begin
         if (i_raddr == ADDR_W'(i)) o_rdata = r_mem[i];
      end
      if (i_raddr == '0) o_rdata = ID_VAL;
   end

   assign o_regs_q[7:0] = 8'h00;
   for (genvar g = 1; g < NREGS; g++) begin : g_flat
      assign o_regs_q[8*g +: 8] = r_mem[g];
   end

endmodule

// File: rtl/spi_regfile.sv
// SPI transaction stage: command decode, burst read/write against spi_regbank.
// Define SPI_REGFILE_AUTOINC_EN to advance the address after every data byte.
//
//   state | meaning
//   IDLE  | chip select inactive (or just reset), tx held at 00
//   CMD   | selected, waiting for the R/W + address byte
//   WRITE | each received byte is written to the current address
//   READ  | each received byte fetches the next tx byte
module spi_regfile
   import spi_regfile_pkg::*;
#(
   parameter int          NREGS   = 16,
   parameter logic [7:0]  ID_VAL  = 8'h5A,
   parameter logic [7:0]  OOR_VAL = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cs,
   input  logic                 rx_done,
   input  logic [7:0]           rx,
   output logic [7:0]           tx,
   output logic [NREGS*8-1:0]   regs_q,
   output logic                 wr_stb,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [7:0]           wr_data
);

`ifdef SPI_REGFILE_AUTOINC_EN
   localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] PTR_STEP = '0;
`endif

   state_t              r_state;
   logic                r_cs_meta;
   logic                r_cs_sync;
   logic [ADDR_W-1:0]   r_addr_ptr;

   logic                w_cs_act;
   logic                w_we;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [7:0]          w_rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cs_meta <= 1'b1;
         r_cs_sync <= 1'b1;
      end else begin
         r_cs_meta <= cs;
         r_cs_sync <= r_cs_meta;
      end
   end

   assign w_cs_act  = !r_cs_sync;
   assign w_we      = w_cs_act && rx_done && (r_state == WRITE);
   // The command byte addresses the read port directly so tx is ready one clk later.
   assign w_rd_addr = (r_state == CMD) ? rx[ADDR_W-1:0] : r_addr_ptr;

   spi_regbank #(
      .NREGS   (NREGS),
      .ID_VAL  (ID_VAL),
      .OOR_VAL (OOR_VAL)
   ) u_regbank (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_we),
      .i_waddr  (r_addr_ptr),
      .i_wdata  (rx),
      .i_raddr  (w_rd_addr),
      .o_rdata  (w_rd_data),
      .o_regs_q (regs_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_addr_ptr <= '0;
         tx         <= TX_RST;
         wr_stb     <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'h00;
      end else begin
         wr_stb <= 1'b0;
         if (!w_cs_act) begin
            r_state <= IDLE;
            tx      <= TX_RST;
         end else begin
            case (r_state)
               IDLE: r_state <= CMD;
               CMD: begin
                  if (rx_done) begin
                     if (rx[CMD_RD_BIT]) begin
                        r_state    <= READ;
                        tx         <= w_rd_data;
                        r_addr_ptr <= rx[ADDR_W-1:0] + PTR_STEP;
                     end else begin
                        r_state    <= WRITE;
                        r_addr_ptr <= rx[ADDR_W-1:0];
                     end
                  end
               end
               WRITE: begin
                  if (rx_done) begin
                     wr_stb     <= 1'b1;
                     wr_addr    <= r_addr_ptr;
                     wr_data    <= rx;
                     r_addr_ptr <= r_addr_ptr + PTR_STEP;
                  end
               end
               READ: begin
                  if (rx_done) begin
                     tx         <= w_rd_data;
                     r_addr_ptr <= r_addr_ptr + PTR_STEP;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_regfile.sv
// Bench for spi_regfile: directed scenarios plus random transactions against a transaction-level model.
module tb_spi_regfile;

   localparam int         NREGS   = 16;
   localparam logic [7:0] ID_VAL  = 8'h5A;
   localparam logic [7:0] OOR_VAL = 8'hFF;
`ifdef SPI_REGFILE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic                cs;
   logic                rx_done;
   logic [7:0]          rx;
   logic [7:0]          tx;
   logic [NREGS*8-1:0]  regs_q;
   logic                wr_stb;
   logic [6:0]          wr_addr;
   logic [7:0]          wr_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_mem [128];
   logic [7:0] q_data [$];

   always #5 clk = ~clk;

   spi_regfile #(.NREGS(NREGS), .ID_VAL(ID_VAL), .OOR_VAL(OOR_VAL)) dut (
      .clk     (clk),
      .rst     (rst),
      .cs      (cs),
      .rx_done (rx_done),
      .rx      (rx),
      .tx      (tx),
      .regs_q  (regs_q),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   function automatic logic [7:0] m_rd(input logic [6:0] a);
      if (a == 7'd0) return ID_VAL;
      if (int'(a) < NREGS) return m_mem[a];
      return OOR_VAL;
   endfunction

   function automatic logic [NREGS*8-1:0] m_regs();
      logic [NREGS*8-1:0] r;
      r = '0;
      for (int i = 1; i < NREGS; i++) r[8*i +: 8] = m_mem[i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [7:0] b);
      @(negedge clk);
      rx      = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      rx      = 8'($urandom);
   endtask

   task automatic cs_start();
      @(negedge clk);
      cs = 1'b0;
      idle(4);
   endtask

   task automatic cs_end();
      @(negedge clk);
      cs = 1'b1;
      idle(4);
      chk("tx_after_cs", tx, 8'h00);
      chk("stb_after_cs", wr_stb, 1'b0);
      chk("regs_q", regs_q, m_regs());
   endtask

   // Byte k of a burst targets cmd_addr + k (+1 for reads, whose first byte comes from the command).
   task automatic txn(input logic [7:0] cmd, input int gapmax);
      logic [6:0] a;
      logic [6:0] ad;
      logic       rd;
      a  = cmd[6:0];
      rd = cmd[7];
      cs_start();
      pulse(cmd);
      chk("cmd_tx", tx, rd ? m_rd(a) : 8'h00);
      chk("cmd_stb", wr_stb, 1'b0);
      for (int k = 0; k < q_data.size(); k++) begin
         idle($urandom_range(0, gapmax));
         if (rd) begin
            ad = AUTOINC ? 7'(int'(a) + k + 1) : a;
            pulse(q_data[k]);
            chk("rd_tx", tx, m_rd(ad));
            chk("rd_stb", wr_stb, 1'b0);
         end else begin
            ad = AUTOINC ? 7'(int'(a) + k) : a;
            pulse(q_data[k]);
            chk("wr_stb", wr_stb, 1'b1);
            chk("wr_addr", wr_addr, ad);
            chk("wr_data", wr_data, q_data[k]);
            chk("wr_tx", tx, 8'h00);
            if (ad != 7'd0 && int'(ad) < NREGS) m_mem[ad] = q_data[k];
         end
      end
      cs_end();
   endtask

   initial begin
      logic [7:0] cmd;
      for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
      rst = 1'b1; cs = 1'b1; rx_done = 1'b0; rx = 8'h00;
      idle(3);
      chk("rst_tx", tx, 8'h00);
      chk("rst_stb", wr_stb, 1'b0);
      chk("rst_waddr", wr_addr, 7'd0);
      chk("rst_wdata", wr_data, 8'h00);
      chk("rst_regs", regs_q, '0);
      @(negedge clk) rst = 1'b0;
      idle(2);

      // byte while deselected is ignored
      pulse(8'h01);
      chk("idle_rx_stb", wr_stb, 1'b0);
      chk("idle_rx_tx", tx, 8'h00);

      q_data = {};                         txn(8'h80, 2);
      chk("id_value_model", m_rd(7'd0), 8'h5A);
      q_data = {8'h11, 8'h22, 8'h33};      txn(8'h02, 2);
      q_data = {8'hA0, 8'hB0};             txn(8'h82, 2);
      q_data = {8'hAB};                    txn(8'h10, 1);
      q_data = {8'h00};                    txn(8'h90, 1);
      q_data = {8'h77};                    txn(8'h00, 1);
      q_data = {};                         txn(8'h80, 1);
      q_data = {8'h01, 8'h02};             txn(8'h7F, 1);
      q_data = {};                         txn(8'h05, 1);

      // byte lands in the cycle the synchronized select drops
      cs_start();
      pulse(8'h03);
      @(negedge clk) cs = 1'b1;
      idle(2);
      rx = 8'hEE; rx_done = 1'b1;
      @(negedge clk) rx_done = 1'b0;
      chk("abort_stb", wr_stb, 1'b0);
      idle(3);
      chk("abort_regs", regs_q, m_regs());
      chk("abort_tx", tx, 8'h00);

      // reset in the middle of a write burst
      cs_start();
      pulse(8'h01);
      pulse(8'h44);
      m_mem[1] = 8'h44;
      chk("pre_rst_regs", regs_q, m_regs());
      @(negedge clk) rst = 1'b1;
      #1;
      for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
      chk("midrst_regs", regs_q, '0);
      chk("midrst_tx", tx, 8'h00);
      chk("midrst_stb", wr_stb, 1'b0);
      @(negedge clk) rst = 1'b0;
      idle(4);
      pulse(8'h80);
      chk("post_rst_cmd_tx", tx, ID_VAL);
      cs_end();

      for (int t = 0; t < 30; t++) begin
         q_data = {};
         repeat ($urandom_range(0, 4)) q_data.push_back(8'($urandom));
         cmd = 8'($urandom);
         if ($urandom_range(0, 3) != 0) cmd[6:0] = 7'($urandom_range(0, NREGS + 2));
         txn(cmd, 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
